// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between two requesters.
// After reset an INIT phase writes a fixed pattern into the low INIT_WORDS words. The block
// then moves to RUN, where it arbitrates round-robin between the two requesters.
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   rX_req/we/addr/wd    requester X access request (X = 0: CPU LSU, 1: debug/loader)
//   rX_gnt               access accepted this cycle (combinational from req)
//   rX_rvalid, rX_rd     read data for the read granted in the previous cycle
//   mem_we/addr/wd       memory write enable, address and write data
//   mem_rd               memory read data (registered inside the memory)
//   init_done            high while in RUN
module dmem_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned INIT_WORDS   = 16,
  parameter int unsigned INIT_PATTERN = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wd,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rd,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wd,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam int unsigned CntLastInt = (INIT_WORDS == 0) ? 0 : INIT_WORDS - 1;
  localparam logic [ADDR_W-1:0] CntLast = CntLastInt[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  // Last driven address/data, replayed while idle so the memory pins do not toggle.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wd    = wd_q;
    init_done = 1'b0;
    sel       = 1'b0;
    // Reset dominates every output so it can never turn into a memory write or grant.
    if (resetn) begin
      unique case (state_q)
        StInit: begin
          if (INIT_WORDS == 0) begin
            state_d = StRun;
          end else begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_wd   = (INIT_PATTERN != 0) ? DATA_W'(cnt_q) : '0;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntLast) state_d = StRun;
          end
        end
        StRun: begin
          init_done = 1'b1;
          if (r0_req || r1_req) begin
            // On contention, favour the requester not served most recently.
            sel      = (r0_req && r1_req) ? ~last_q : r1_req;
            r0_gnt   = ~sel;
            r1_gnt   = sel;
            last_d   = sel;
            mem_we   = sel ? r1_we   : r0_we;
            mem_addr = sel ? r1_addr : r0_addr;
            mem_wd   = sel ? r1_wd   : r0_wd;
            rv0_d    = ~sel & ~r0_we;
            rv1_d    = sel & ~r1_we;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StInit;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      addr_q  <= mem_addr;
      wd_q    <= mem_wd;
    end
  end

  // A reset in the cycle after a read grant must hide the pending rvalid.
  assign r0_rvalid = rv0_q & resetn;
  assign r1_rvalid = rv1_q & resetn;
  assign r0_rd     = mem_rd;
  assign r1_rd     = mem_rd;

endmodule
